// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and PC/link/status outputs of the program-counter sequencer.
interface pc_sequencer_if #(parameter int PC_W = 16);
  logic            stall;
  logic            jump;
  logic            jal;
  logic            jump_reg;
  logic            branch_eq;
  logic            branch_ne;
  logic            halt;
  logic            resume;
  logic            zero;
  logic [7:0]      offset;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] reg_addr;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] link_addr;
  logic            link_we;
  logic            halted;
  logic [15:0]     retired;
  modport master (
    output stall, jump, jal, jump_reg, branch_eq, branch_ne, halt, resume, zero, offset, target, reg_addr,
    input  pc, link_addr, link_we, halted, retired
  );
  modport slave (
    input  stall, jump, jal, jump_reg, branch_eq, branch_ne, halt, resume, zero, offset, target, reg_addr,
    output pc, link_addr, link_we, halted, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: RUN/HALT program-counter sequencer with jumps, JAL link write, branches and a saturating retire count.
module pc_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             rst,
  pc_sequencer_if.slave   bus
);
  typedef enum logic {RUN, HALT} state_t;
  state_t          state, state_n;
  logic [PC_W-1:0] pc_n, link_n, pc_inc, br_pc;
  logic [15:0]     retired_n;
  logic            we_n, accept, taken;
  always_comb begin
    accept    = state == RUN && !bus.stall;
    taken     = (bus.branch_eq & bus.zero) | (bus.branch_ne & ~bus.zero);
    pc_inc    = bus.pc + PC_W'(1);
    br_pc     = pc_inc + {{(PC_W-8){bus.offset[7]}}, bus.offset};
    state_n   = state;
    pc_n      = bus.pc;
    we_n      = 1'b0;
    retired_n = bus.retired;
    if (accept) begin
      state_n   = bus.halt ? HALT : RUN;
      pc_n      = bus.halt ? bus.pc : bus.jump_reg ? bus.reg_addr : (bus.jal | bus.jump) ? bus.target : taken ? br_pc : pc_inc;
      we_n      = bus.jal & ~bus.halt & ~bus.jump_reg;
      retired_n = &bus.retired ? bus.retired : bus.retired + 16'd1;
    end else if (state == HALT && !bus.stall && bus.resume) begin
      state_n = RUN;
      pc_n    = pc_inc;
    end
    link_n = we_n ? pc_inc : bus.link_addr;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      bus.pc        <= RESET_PC;
      bus.link_addr <= '0;
      bus.link_we   <= 1'b0;
      bus.retired   <= '0;
    end else begin
      state         <= state_n;
      bus.pc        <= pc_n;
      bus.link_addr <= link_n;
      bus.link_we   <= we_n;
      bus.retired   <= retired_n;
    end
  end
  assign bus.halted = state == HALT;
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 16, program-counter width in bits.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 Stall  input  1  when high, freezes all state (PC, state, counter, link outputs held/deasserted per REQ-019).
REQ-006 Jump  input  1  unconditional jump to Target.
REQ-007 Jal  input  1  jump to Target and write link address.
REQ-008 Jump_Reg  input  1  jump to Reg_Addr.
REQ-009 Branch_EQ  input  1  branch if Zero=1.
REQ-010 Branch_NE  input  1  branch if Zero=0.
REQ-011 Halt  input  1  enter HALT state.
REQ-012 Resume  input  1  leave HALT state.
REQ-013 Zero  input  1  ALU zero flag for the current instruction.
REQ-014 Offset  input  8  signed two's-complement branch offset, in words.
REQ-015 Target  input  PC_W  absolute jump address.
REQ-016 Reg_Addr  input  PC_W  register-sourced jump address.
REQ-017 PC  output  PC_W  address of the instruction currently being executed.
REQ-018 Link_Addr  output  PC_W  return address (PC+1) registered on a JAL.
REQ-019 Link_WE  output  1  one-cycle pulse in the cycle after an accepted JAL.
REQ-020 Halted  output  1  high while in HALT state.
REQ-021 Retired  output  16  count of instructions accepted in RUN state, saturating at 16'hFFFF.

Function
REQ-022 Two states, RUN and HALT; an instruction is "accepted" on a rising edge with state=RUN and Stall=0.
REQ-023 On acceptance, next PC priority: Halt > Jump_Reg > Jal > Jump > taken branch > PC+1.
REQ-024 Halt accepted: PC holds its current value; state -> HALT; Retired increments.
REQ-025 Jump_Reg: PC <= Reg_Addr; Jal and Jump: PC <= Target.
REQ-026 Branch taken when (Branch_EQ & Zero) | (Branch_NE & ~Zero); PC <= PC + 1 + sign_extend(Offset).
REQ-027 All PC arithmetic modulo 2^PC_W; wrap-around is silent (e.g. PC = max value + 1 -> 0).
REQ-028 Jal accepted: Link_Addr <= PC + 1 (mod 2^PC_W); Link_WE = 1 for exactly the following cycle; Link_Addr holds until the next JAL.
REQ-029 Jal asserted together with higher-priority Halt or Jump_Reg: no link write.
REQ-030 Stall=1: PC, state, Retired, Link_Addr unchanged; Link_WE = 0 for that edge.
REQ-031 In HALT: PC, Retired held; all control inputs except Resume and Stall ignored.
REQ-032 HALT with Resume=1 and Stall=0: state -> RUN, PC <= PC + 1; the edge does not count as an accepted instruction.
REQ-033 Retired saturates at 16'hFFFF and does not wrap.
REQ-034 Halted is a registered output: high in the first cycle after the edge that accepted Halt.

Reset
REQ-035 RST high: PC = RESET_PC, state = RUN, Halted = 0, Link_Addr = 0, Link_WE = 0, Retired = 0, all immediately, regardless of CLK.
REQ-036 RST asserted mid-JAL pulse or in HALT: Link_WE cleared and state forced to RUN at once; resumes from RESET_PC on the first edge after release.

Verification
REQ-037 Reset release, no control inputs, 5 edges -> PC 0,1,2,3,4,5; Retired = 5.
REQ-038 PC = 0x0010, Branch_EQ=1, Zero=1, Offset=8'hFC -> PC = 0x000D; same with Zero=0 -> PC = 0x0011.
REQ-039 PC = 0x0020, Jal=1, Target=0x0100 -> PC = 0x0100, Link_Addr = 0x0021, Link_WE high for one cycle only.
REQ-040 PC = 0x0030, Halt=1 and Jump=1 together -> PC stays 0x0030, Halted=1; 3 edges later still 0x0030; Resume=1 -> PC = 0x0031, Halted=0.
REQ-041 PC = 0xFFFF, no control inputs -> PC = 0x0000; Stall=1 for 4 edges with Jump=1 -> PC and Retired unchanged.
REQ-042 RST pulsed asynchronously between edges while Halted=1 -> PC = 0x0000 and Halted=0 before the next edge.
